alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter FIXED_PRIO, default 0; 0 = round-robin, 1 = requester 0 always wins.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports reqN_valid  input  1  requester N (N=0,1) offers an op.
REQ-005 SHALL have ports reqN_ready  output  1  op accepted this cycle.
REQ-006 SHALL have ports reqN_op  input  4  ALU control code.
REQ-007 SHALL have ports reqN_a, reqN_b  input  32  operands.
REQ-008 SHALL have ports rspN_valid  output  1  result available to requester N.
REQ-009 SHALL have ports rspN_ready  input  1  requester N takes the result.
REQ-010 SHALL have ports rspN_data  output  32  result.
REQ-011 SHALL have ports rspN_zero, rspN_err  output  1  zero flag; illegal-opcode flag.
REQ-012 SHALL have ports alu_srca, alu_srcb  output  32  operands to the shared combinational ALU.
REQ-013 SHALL have port alu_ctrl  output  4  control code to the shared ALU.
REQ-014 SHALL have ports alu_out  input  32  and alu_zero  input  1  ALU results.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement the states IDLE, EXEC and RESP.
REQ-017 In IDLE with any reqN_valid high, SHALL grant one requester and pulse its reqN_ready for that cycle, latch op, a and b, record the owner, and go to EXEC.
REQ-018 With FIXED_PRIO=0 and both requesters valid, SHALL grant the requester not granted last; the first contention after reset goes to 0.
REQ-019 SHALL raise reqN_ready only in IDLE, never for both requesters, and never while reqN_valid is low.
REQ-020 In EXEC, SHALL drive alu_srca, alu_srcb and alu_ctrl from the latched values, capture alu_out and alu_zero at the clock edge, and go to RESP.
REQ-021 Outside EXEC, SHALL hold alu_srca, alu_srcb and alu_ctrl at 0.
REQ-022 The legal opcodes SHALL be 0000, 0001, 0010, 0011, 0101, 0110, 0111, 1000, 1011, 1100 and 1101.
REQ-023 For an illegal opcode, EXEC SHALL still last one cycle, with alu_ctrl held at 0 and the result set to data=0, zero=0, err=1.
REQ-024 In RESP, SHALL hold rsp<owner>_valid high and the result stable until rsp<owner>_ready is high, then go to IDLE and update the last-grant record.
REQ-025 The non-owner rspN_valid SHALL stay 0.
REQ-026 Latency SHALL be fixed: with acceptance in cycle T, rsp_valid rises in T+2; with rsp_ready already high, the next acceptance is no earlier than T+3.
REQ-027 Requests arriving in EXEC or RESP SHALL wait with ready low, and requesters SHALL hold reqN_* stable until ready is seen.
REQ-028 Operands SHALL pass through unmodified at 32 bits; the block SHALL perform no arithmetic itself.

Reset
REQ-029 Reset SHALL force IDLE, with every output 0, the latched op/operands/result at 0, and the last-grant record set to 1 so requester 0 wins first.
REQ-030 Reset asserted in EXEC or RESP SHALL discard the in-flight op with no response issued, and after reset release the block SHALL accept in the next cycle.

Structure
REQ-031 A shared package SHALL hold the opcode constants, the state enum, the legal-opcode check function and the parameter default.
REQ-032 The round-robin grant logic SHALL be a separate sub-module, alu_rr_grant (inputs: valid vector and last-grant; output: one-hot grant).
REQ-033 The ALU SHALL stay outside this block and be connected at the next level up.

Verification
REQ-034 Single op: req0 op 0010, a=5, b=7 -> rsp0_valid 2 cycles after acceptance, data=12, zero=0, err=0.
REQ-035 Subtract to zero: req1 op 0110, a=b=0x1234 -> rsp1_data=0, rsp1_zero=1, rsp0_valid stays 0.
REQ-036 Contention: both valid continuously with RR, 4 ops -> grants alternate 0,1,0,1; with FIXED_PRIO=1 -> 0,0,0,0.
REQ-037 Backpressure: rsp0_ready held low 5 cycles -> data stable, busy=1, req1_ready=0 throughout, and after the handshake req1 is accepted the next cycle.
REQ-038 Illegal opcode 1111 -> err=1, data=0, alu_ctrl=0 during EXEC.
REQ-039 rst pulsed mid-EXEC -> all outputs 0 asynchronously, no rsp_valid afterwards, and a new req0 is accepted the first cycle after release.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// ============================================================================
// Module : alu_arbiter_pkg
// Brief  : Shared opcodes, FSM states and legal-opcode check for alu_arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package alu_arbiter_pkg;

    localparam int FIXED_PRIO_DEFAULT = 0;

    localparam logic [3:0] C_OP_AND  = 4'b0000;
    localparam logic [3:0] C_OP_OR   = 4'b0001;
    localparam logic [3:0] C_OP_ADD  = 4'b0010;
    localparam logic [3:0] C_OP_XOR  = 4'b0011;
    localparam logic [3:0] C_OP_SLL  = 4'b0101;
    localparam logic [3:0] C_OP_SUB  = 4'b0110;
    localparam logic [3:0] C_OP_SLT  = 4'b0111;
    localparam logic [3:0] C_OP_SRL  = 4'b1000;
    localparam logic [3:0] C_OP_SRA  = 4'b1011;
    localparam logic [3:0] C_OP_NOR  = 4'b1100;
    localparam logic [3:0] C_OP_SLTU = 4'b1101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    function automatic logic is_legal_op(input logic [3:0] op);
        logic legal;
        case (op)
            C_OP_AND, C_OP_OR, C_OP_ADD, C_OP_XOR, C_OP_SLL, C_OP_SUB,
            C_OP_SLT, C_OP_SRL, C_OP_SRA, C_OP_NOR, C_OP_SLTU: legal = 1'b1;
            default:                                           legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_rr_grant.sv
// ============================================================================
// Module : alu_rr_grant
// Brief  : Two-way one-hot grant; round-robin on last winner or fixed prio 0.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alu_rr_grant
    import alu_arbiter_pkg::*;
#(
    parameter int FIXED_PRIO = FIXED_PRIO_DEFAULT
) (
    input  logic [1:0] valid,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = valid;
        // Under contention the requester that did not win last time goes first.
        if (valid == 2'b11) begin
            if (FIXED_PRIO != 0) begin
                grant = 2'b01;
            end else begin
                grant = last ? 2'b01 : 2'b10;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
// Module : alu_arbiter
// Brief  : Shares one external combinational ALU between two requesters.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int FIXED_PRIO = FIXED_PRIO_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_data,
    output logic        rsp0_zero,
    output logic        rsp0_err,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_data,
    output logic        rsp1_zero,
    output logic        rsp1_err,
    output logic [31:0] alu_srca,
    output logic [31:0] alu_srcb,
    output logic [3:0]  alu_ctrl,
    input  logic [31:0] alu_out,
    input  logic        alu_zero,
    output logic        busy
);

    state_e      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] data_q, data_d;
    logic        zero_q, zero_d;
    logic        err_q, err_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;

    logic [1:0]  w_grant;
    logic        w_accept_en;
    logic        w_exec;
    logic        w_legal;
    logic        w_rsp0;
    logic        w_rsp1;

    alu_rr_grant #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_grant (
        .valid (({req1_valid, req0_valid})),
        .last  (last_q),
        .grant (w_grant)
    );

    // Ready is also masked by rst so every output reads 0 while reset is held.
    assign w_accept_en = (state_q == IDLE) && !rst;
    assign req0_ready  = w_accept_en && w_grant[0];
    assign req1_ready  = w_accept_en && w_grant[1];

    assign w_exec   = (state_q == EXEC);
    assign w_legal  = is_legal_op(op_q);
    assign alu_srca = w_exec ? a_q : 32'd0;
    assign alu_srcb = w_exec ? b_q : 32'd0;
    assign alu_ctrl = (w_exec && w_legal) ? op_q : 4'd0;

    assign w_rsp0     = (state_q == RESP) && !owner_q;
    assign w_rsp1     = (state_q == RESP) &&  owner_q;
    assign rsp0_valid = w_rsp0;
    assign rsp0_data  = w_rsp0 ? data_q : 32'd0;
    assign rsp0_zero  = w_rsp0 && zero_q;
    assign rsp0_err   = w_rsp0 && err_q;
    assign rsp1_valid = w_rsp1;
    assign rsp1_data  = w_rsp1 ? data_q : 32'd0;
    assign rsp1_zero  = w_rsp1 && zero_q;
    assign rsp1_err   = w_rsp1 && err_q;

    assign busy = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        data_d  = data_q;
        zero_d  = zero_q;
        err_d   = err_q;
        owner_d = owner_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (w_grant != 2'b00) begin
                    owner_d = w_grant[1];
                    op_d    = w_grant[1] ? req1_op : req0_op;
                    a_d     = w_grant[1] ? req1_a  : req0_a;
                    b_d     = w_grant[1] ? req1_b  : req0_b;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (w_legal) begin
                    data_d = alu_out;
                    zero_d = alu_zero;
                    err_d  = 1'b0;
                end else begin
                    data_d = 32'd0;
                    zero_d = 1'b0;
                    err_d  = 1'b1;
                end
                state_d = RESP;
            end
            RESP: begin
                if (owner_q ? rsp1_ready : rsp0_ready) begin
                    last_d  = owner_q;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= 4'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            data_q  <= 32'd0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            data_q  <= data_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// Module : tb_alu_arbiter
// Brief  : Self-checking bench for alu_arbiter with a reference ALU attached.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [3:0]  req0_op = 4'd0, req1_op = 4'd0;
    logic [31:0] req0_a = 32'd0, req0_b = 32'd0, req1_a = 32'd0, req1_b = 32'd0;
    logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;
    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [31:0] rsp0_data, rsp1_data, alu_srca, alu_srcb, alu_out;
    logic        rsp0_zero, rsp0_err, rsp1_zero, rsp1_err, alu_zero, busy;
    logic [3:0]  alu_ctrl;

    logic        fp_v0 = 1'b0, fp_v1 = 1'b0;
    logic        fp_r0, fp_r1, fp_rv0, fp_rv1, fp_z0, fp_e0, fp_z1, fp_e1, fp_busy;
    logic [31:0] fp_d0, fp_d1, fp_srca, fp_srcb, fp_alu_out;
    logic [3:0]  fp_ctrl;
    logic        fp_alu_zero;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference ALU living one level up from the arbiter.
    function automatic logic [31:0] alu_fn(input logic [3:0] c, input logic [31:0] a,
                                           input logic [31:0] b);
        case (c)
            4'h0: return a & b;
            4'h1: return a | b;
            4'h2: return a + b;
            4'h3: return a ^ b;
            4'h5: return a << b[4:0];
            4'h6: return a - b;
            4'h7: return {31'd0, $signed(a) < $signed(b)};
            4'h8: return a >> b[4:0];
            4'hB: return $unsigned($signed(a) >>> b[4:0]);
            4'hC: return ~(a | b);
            4'hD: return {31'd0, a < b};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic legal_ref(input logic [3:0] c);
        return c inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7, 4'h8, 4'hB, 4'hC, 4'hD};
    endfunction

    assign alu_out     = alu_fn(alu_ctrl, alu_srca, alu_srcb);
    assign alu_zero    = (alu_out == 32'd0);
    assign fp_alu_out  = alu_fn(fp_ctrl, fp_srca, fp_srcb);
    assign fp_alu_zero = (fp_alu_out == 32'd0);

    alu_arbiter #(.FIXED_PRIO(0)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
        .rsp0_zero(rsp0_zero), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
        .rsp1_zero(rsp1_zero), .rsp1_err(rsp1_err),
        .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_ctrl(alu_ctrl),
        .alu_out(alu_out), .alu_zero(alu_zero), .busy(busy)
    );

    alu_arbiter #(.FIXED_PRIO(1)) dut_fp (
        .clk(clk), .rst(rst),
        .req0_valid(fp_v0), .req0_ready(fp_r0), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(fp_v1), .req1_ready(fp_r1), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(fp_rv0), .rsp0_ready(1'b1), .rsp0_data(fp_d0),
        .rsp0_zero(fp_z0), .rsp0_err(fp_e0),
        .rsp1_valid(fp_rv1), .rsp1_ready(1'b1), .rsp1_data(fp_d1),
        .rsp1_zero(fp_z1), .rsp1_err(fp_e1),
        .alu_srca(fp_srca), .alu_srcb(fp_srcb), .alu_ctrl(fp_ctrl),
        .alu_out(fp_alu_out), .alu_zero(fp_alu_zero), .busy(fp_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: got timeout expected event (t=%0t)", name, $time);
    endtask

    // ---------------- transaction-level model (round-robin instance) ---------
    logic        m_busy = 1'b0, m_owner = 1'b0, m_last = 1'b1;
    int          m_age = 0;
    logic [3:0]  m_op = 4'd0;
    logic [31:0] m_a = 32'd0, m_b = 32'd0;
    logic [1:0]  m_g;

    function automatic logic [1:0] rule_grant(input logic v0, input logic v1, input logic last);
        int winner;
        if (v0 && v1) begin
            winner = (last == 1'b1) ? 0 : 1;
            return 2'(1 << winner);
        end
        return {v1, v0};
    endfunction

    assign m_g = rule_grant(req0_valid, req1_valid, m_last);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0; m_age <= 0; m_owner <= 1'b0; m_last <= 1'b1;
            m_op <= 4'd0; m_a <= 32'd0; m_b <= 32'd0;
        end else if (!m_busy) begin
            if (m_g != 2'b00) begin
                m_busy  <= 1'b1;
                m_age   <= 1;
                m_owner <= m_g[1];
                m_op    <= m_g[1] ? req1_op : req0_op;
                m_a     <= m_g[1] ? req1_a  : req0_a;
                m_b     <= m_g[1] ? req1_b  : req0_b;
            end
        end else if (m_age == 1) begin
            m_age <= 2;
        end else if (m_owner ? rsp1_ready : rsp0_ready) begin
            m_busy <= 1'b0;
            m_last <= m_owner;
        end
    end

    logic        c_exec, c_rv0, c_rv1;
    logic [31:0] c_data;

    always @(negedge clk) begin
        c_exec = m_busy && (m_age == 1);
        c_rv0  = m_busy && (m_age == 2) && !m_owner;
        c_rv1  = m_busy && (m_age == 2) &&  m_owner;
        c_data = legal_ref(m_op) ? alu_fn(m_op, m_a, m_b) : 32'd0;
        chk("req0_ready", 32'(req0_ready), 32'(!rst && !m_busy && m_g[0]));
        chk("req1_ready", 32'(req1_ready), 32'(!rst && !m_busy && m_g[1]));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("alu_srca", alu_srca, c_exec ? m_a : 32'd0);
        chk("alu_srcb", alu_srcb, c_exec ? m_b : 32'd0);
        chk("alu_ctrl", 32'(alu_ctrl), 32'((c_exec && legal_ref(m_op)) ? m_op : 4'd0));
        chk("rsp0_valid", 32'(rsp0_valid), 32'(c_rv0));
        chk("rsp1_valid", 32'(rsp1_valid), 32'(c_rv1));
        if (c_rv0 || c_rv1) begin
            chk("rsp_data", c_rv0 ? rsp0_data : rsp1_data, c_data);
            chk("rsp_zero", 32'(c_rv0 ? rsp0_zero : rsp1_zero),
                32'(legal_ref(m_op) && c_data == 32'd0));
            chk("rsp_err", 32'(c_rv0 ? rsp0_err : rsp1_err), 32'(!legal_ref(m_op)));
        end
    end

    // ---------------- directed stimulus --------------------------------------
    task automatic send(input int n, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, output int acc);
        acc = -1;
        if (n == 0) begin req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; end
        else        begin req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (n == 0 ? req0_ready : req1_ready) begin
                acc = cyc;
                @(posedge clk); #1;
                if (n == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
                return;
            end
        end
        timeout("send_accept");
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int n, output int c);
        c = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (n == 0 ? rsp0_valid : rsp1_valid) begin c = cyc; return; end
        end
        timeout("wait_rsp");
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!busy && !fp_busy) begin @(posedge clk); #1; return; end
        end
        timeout("wait_idle");
    endtask

    int ac, rc;
    int got_rr[4], got_fp[4];
    int n_rr, n_fp;
    int exp_rr[4] = '{0, 1, 0, 1};
    logic [31:0] held;

    initial begin
        // Reset state, with a request already pending.
        req0_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req0_ready", 32'(req0_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
        chk("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
        chk("rst_rsp0_data", rsp0_data, 32'd0);
        req0_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        // 5 + 7 on requester 0, two-cycle latency.
        send(0, 4'b0010, 32'd5, 32'd7, ac);
        wait_rsp(0, rc);
        chk("add_latency", 32'(rc - ac), 32'd2);
        chk("add_data", rsp0_data, 32'd12);
        chk("add_zero", 32'(rsp0_zero), 32'd0);
        chk("add_err", 32'(rsp0_err), 32'd0);
        wait_idle();

        // Subtract to zero on requester 1.
        send(1, 4'b0110, 32'h1234, 32'h1234, ac);
        wait_rsp(1, rc);
        chk("sub_data", rsp1_data, 32'd0);
        chk("sub_zero", 32'(rsp1_zero), 32'd1);
        chk("sub_rsp0_valid", 32'(rsp0_valid), 32'd0);
        wait_idle();

        // Contention on both instances, straight out of reset.
        rst = 1'b1; #2; rst = 1'b0;
        req0_op = 4'b0010; req0_a = 32'd1; req0_b = 32'd2;
        req1_op = 4'b0011; req1_a = 32'hF0; req1_b = 32'h0F;
        req0_valid = 1'b1; req1_valid = 1'b1; fp_v0 = 1'b1; fp_v1 = 1'b1;
        got_rr = '{-1, -1, -1, -1}; got_fp = '{-1, -1, -1, -1};
        n_rr = 0; n_fp = 0;
        for (int i = 0; i < 40 && (n_rr < 4 || n_fp < 4); i++) begin
            @(negedge clk);
            if (n_rr < 4 && (req0_ready || req1_ready)) begin
                got_rr[n_rr] = req1_ready ? 1 : 0; n_rr++;
            end
            if (n_fp < 4 && (fp_r0 || fp_r1)) begin
                got_fp[n_fp] = fp_r1 ? 1 : 0; n_fp++;
            end
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0; fp_v0 = 1'b0; fp_v1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rr_grant%0d", k), 32'(got_rr[k]), 32'(exp_rr[k]));
            chk($sformatf("fp_grant%0d", k), 32'(got_fp[k]), 32'd0);
        end
        wait_idle();

        // Backpressure on requester 0 while requester 1 waits.
        rsp0_ready = 1'b0;
        send(0, 4'b0010, 32'd100, 32'd23, ac);
        req1_valid = 1'b1; req1_op = 4'b0010; req1_a = 32'd1; req1_b = 32'd1;
        wait_rsp(0, rc);
        held = rsp0_data;
        chk("bp_data", held, 32'd123);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("bp_stable", rsp0_data, held);
            chk("bp_busy", 32'(busy), 32'd1);
            chk("bp_req1_ready", 32'(req1_ready), 32'd0);
        end
        @(posedge clk); #1;
        rsp0_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_req1_next", 32'(req1_ready), 32'd1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        wait_rsp(1, rc);
        chk("bp_req1_data", rsp1_data, 32'd2);
        wait_idle();

        // Illegal opcode.
        send(0, 4'b1111, 32'hDEAD, 32'hBEEF, ac);
        @(negedge clk);
        chk("ill_alu_ctrl", 32'(alu_ctrl), 32'd0);
        chk("ill_busy", 32'(busy), 32'd1);
        wait_rsp(0, rc);
        chk("ill_err", 32'(rsp0_err), 32'd1);
        chk("ill_data", rsp0_data, 32'd0);
        chk("ill_zero", 32'(rsp0_zero), 32'd0);
        wait_idle();

        // Reset in the middle of EXEC.
        send(0, 4'b0010, 32'd1, 32'd2, ac);
        #1; rst = 1'b1; #1;
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_srca", alu_srca, 32'd0);
        chk("mid_ctrl", 32'(alu_ctrl), 32'd0);
        chk("mid_rsp0_valid", 32'(rsp0_valid), 32'd0);
        @(posedge clk); #2;
        req0_valid = 1'b1; req0_op = 4'b0010; req0_a = 32'd9; req0_b = 32'd1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_accept", 32'(req0_ready), 32'd1);
        chk("mid_no_rsp", 32'(rsp0_valid), 32'd0);
        ac = cyc;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        wait_rsp(0, rc);
        chk("mid_latency", 32'(rc - ac), 32'd2);
        chk("mid_data", rsp0_data, 32'd10);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
